// File: rtl/hps_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hps_cmd_pkg
//  Purpose  : Shared types and constants for the HPS command controller:
//             command field layout, special opcodes, status bit positions
//             and the controller state enumeration.
//  Revision : 1.0 - initial release
// ============================================================================
package hps_cmd_pkg;

  // Command word layout: [17:15] opcode, [14:0] operand
  localparam int CMD_W  = 18;
  localparam int OPC_W  = 3;
  localparam int OPD_W  = 15;
  localparam int DATA_W = 8;
  localparam int STAT_W = 3;

  // Opcodes handled locally; everything else is forwarded to the engine
  localparam logic [OPC_W-1:0] OP_NOP       = 3'b000;
  localparam logic [OPC_W-1:0] OP_READ_NEXT = 3'b111;

  // Bit positions inside rsp_status
  localparam int ST_DONE = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_ERR  = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    EXEC     = 2'd1,
    WAIT_ENG = 2'd2,
    RESPOND  = 2'd3
  } state_t;

  // True for opcodes that must be sequenced through the processing engine
  function automatic logic is_engine_op(input logic [OPC_W-1:0] op);
    return (op != OP_NOP) && (op != OP_READ_NEXT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rsp_byte_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : rsp_byte_fifo
//  Purpose  : Circular result-byte buffer with first-word-fall-through read.
//             A push into a full buffer is dropped; a pop from an empty one
//             is ignored. flush empties the buffer in one cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module rsp_byte_fifo #(
  parameter int RES_DEPTH = 4,
  parameter int DATA_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_ptr_one   = 1;
  localparam logic [PTR_W:0]   c_cnt_one   = 1;
  localparam logic [PTR_W:0]   c_cnt_depth = (PTR_W+1)'(RES_DEPTH);

  logic [DATA_W-1:0] r_mem [RES_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  logic w_do_push;
  logic w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == c_cnt_depth);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr];

  // Storage array; contents are don't-care while the buffer is empty
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + c_cnt_one;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - c_cnt_one;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hps_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hps_cmd_ctrl
//  Purpose  : Command controller between the HPS PIO ports and the FPGA
//             processing engine. Accepts an 18-bit command on a four-phase
//             level strobe, runs NOP / READ_NEXT locally, sequences engine
//             opcodes through a start/done handshake, buffers result bytes
//             and returns them one per READ_NEXT with done/busy/error flags.
//  Options  : define CMD_TIMEOUT_EN to enable the engine watchdog
//             (TIMEOUT_CYCLES) and the eng_abort pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module hps_cmd_ctrl
  import hps_cmd_pkg::*;
#(
  parameter int RES_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  cmd_word,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [STAT_W-1:0] rsp_status,
  output logic              eng_start,
  output logic [OPC_W-1:0]  eng_opcode,
  output logic [OPD_W-1:0]  eng_operand,
  output logic              eng_abort,
  input  logic              eng_done,
  input  logic              eng_err,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data
);

  state_t            r_state;
  logic              r_cmd_q;
  logic              r_done;
  logic              r_busy;
  logic              r_err;
  logic              r_ovf;
  logic              r_start;
  logic [OPC_W-1:0]  r_opcode;
  logic [OPD_W-1:0]  r_operand;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_flush;
  logic              w_ovf_now;
  logic              w_tmo_hit;
  logic [DATA_W-1:0] w_fifo_dout;
  logic              w_empty;
  logic              w_full;

  // Rising edge of the HPS strobe, only honoured while idle
  assign w_accept  = (r_state == IDLE) && cmd_valid && !r_cmd_q;
  // Buffer traffic is confined to EXEC (pop/flush) and WAIT_ENG (push)
  assign w_push    = (r_state == WAIT_ENG) && res_valid;
  assign w_pop     = (r_state == EXEC) && (r_opcode == OP_READ_NEXT);
  assign w_flush   = (r_state == EXEC) && is_engine_op(r_opcode);
  assign w_ovf_now = w_push && w_full;

  rsp_byte_fifo #(
    .RES_DEPTH (RES_DEPTH),
    .DATA_W    (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (res_data),
    .dout  (w_fifo_dout),
    .empty (w_empty),
    .full  (w_full)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] c_tmo_one  = 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_abort;

  // eng_done in the expiry cycle wins over the watchdog
  assign w_tmo_hit = (r_state == WAIT_ENG) && !eng_done && (r_tmo_cnt == c_tmo_last);
  assign eng_abort = r_abort;

  // Watchdog: cleared on entry to WAIT_ENG, counts every cycle spent there
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo_cnt <= '0;
      r_abort   <= 1'b0;
    end else begin
      r_abort <= w_tmo_hit;
      if (r_state != WAIT_ENG) begin
        r_tmo_cnt <= '0;
      end else begin
        r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
      end
    end
  end
`else
  assign w_tmo_hit = 1'b0;
  assign eng_abort = 1'b0;
`endif

  // Strobe history; resets high so a strobe held through reset is ignored
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cmd_q <= 1'b1;
    end else begin
      r_cmd_q <= cmd_valid;
    end
  end

  // Main sequencer with registered status, start pulse and response byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_start    <= 1'b0;
      r_opcode   <= '0;
      r_operand  <= '0;
      r_rsp_data <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opcode  <= cmd_word[CMD_W-1 -: OPC_W];
            r_operand <= cmd_word[OPD_W-1:0];
            r_err     <= 1'b0;
            r_state   <= EXEC;
          end
        end
        EXEC: begin
          if (r_opcode == OP_NOP) begin
            r_done  <= 1'b1;
            r_state <= RESPOND;
          end else if (r_opcode == OP_READ_NEXT) begin
            if (!w_empty) begin
              r_rsp_data <= w_fifo_dout;
            end else begin
              r_err <= 1'b1;
            end
            r_done  <= 1'b1;
            r_state <= RESPOND;
          end else begin
            r_ovf   <= 1'b0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= WAIT_ENG;
          end
        end
        WAIT_ENG: begin
          if (eng_done) begin
            // A byte dropped in this very cycle still counts as overflow
            r_err   <= eng_err | r_ovf | w_ovf_now;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= RESPOND;
          end else begin
            if (w_ovf_now) begin
              r_ovf <= 1'b1;
            end
            if (w_tmo_hit) begin
              r_err   <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= RESPOND;
            end
          end
        end
        RESPOND: begin
          if (!cmd_valid) begin
            r_done  <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rsp_data            = r_rsp_data;
  assign rsp_status[ST_DONE] = r_done;
  assign rsp_status[ST_BUSY] = r_busy;
  assign rsp_status[ST_ERR]  = r_err;
  assign eng_start           = r_start;
  assign eng_opcode          = r_opcode;
  assign eng_operand         = r_operand;

endmodule
`default_nettype wire

// File: doc/hps_cmd_ctrl.md
Name: hps_cmd_ctrl

Overview:
Command controller between the HPS parallel-I/O ports and the FPGA-side processing engine.
- HPS writes an 18-bit command word and raises a 1-bit level strobe.
- The block decodes the word, sequences the engine through a start/done handshake and buffers the engine's result bytes.
- It returns one byte at a time on an 8-bit data port, plus 3 status flags, using a four-phase handshake.

Parameters:
RES_DEPTH, 4, result byte buffer depth (power of 2, ≥2)
TIMEOUT_CYCLES, 1000000, engine watchdog limit in clk cycles (used only with CMD_TIMEOUT_EN)

Ports:
clk  in  1  system clock (same clock as the HPS PIO fabric)
reset  in  1  asynchronous, active-high reset
cmd_word  in  18  command from HPS: [17:15] opcode, [14:0] operand
cmd_valid  in  1  HPS command strobe, level, four-phase
rsp_data  out  8  result byte to HPS
rsp_status  out  3  [0] done, [1] busy, [2] error
eng_start  out  1  one-cycle engine start pulse
eng_opcode  out  3  latched opcode to engine
eng_operand  out  15  latched operand to engine
eng_abort  out  1  one-cycle abort pulse (tied 0 without CMD_TIMEOUT_EN)
eng_done  in  1  engine completion pulse
eng_err  in  1  engine error, sampled with eng_done
res_valid  in  1  engine result byte strobe
res_data  in  8  engine result byte

Behaviour:
- Reset state:
  - All outputs 0; state IDLE; buffer empty; error flag 0.
  - cmd_q resets to 1, so a strobe held high across reset is not accepted.
- Accept condition: cmd_valid=1 and cmd_q=0 while in IDLE. cmd_q registers cmd_valid every cycle.
- On accept:
  - Latch cmd_word.
  - Clear the error flag.
- States:
  - IDLE → (accept) EXEC.
  - EXEC, opcode 3'b000 NOP: go to RESPOND.
  - EXEC, opcode 3'b111 READ_NEXT:
    - Buffer non-empty: pop the head byte into rsp_data, then RESPOND.
    - Buffer empty: set error, leave rsp_data unchanged, then RESPOND.
  - EXEC, opcodes 001–110:
    - Flush the buffer.
    - Drive eng_start=1 for exactly this cycle; eng_opcode/eng_operand stay valid until the next accept.
    - Go to WAIT_ENG.
  - WAIT_ENG:
    - busy=1.
    - res_valid pushes res_data. A push when full drops the byte and sets the overflow flag.
    - eng_done: error ← eng_err | overflow; go to RESPOND. A res_valid in the same cycle as eng_done is stored.
  - RESPOND: done=1; hold until cmd_valid=0, then IDLE. done clears on the same edge.
- Latency:
  - NOP/READ_NEXT: done visible 2 edges after the first edge sampling cmd_valid=1.
  - Engine ops: done visible 1 edge after the edge sampling eng_done.
- Flag rules:
  - error persists through IDLE until the next accept.
  - busy is 0 outside WAIT_ENG.
  - res_valid and eng_done outside WAIT_ENG are ignored.
- Buffer:
  - Circular; read/write pointers wrap modulo RES_DEPTH; count ranges 0..RES_DEPTH.
  - Pops occur only in EXEC and pushes only in WAIT_ENG, so a simultaneous push and pop cannot occur.
- Reset mid-operation: immediate return to reset state; partially received results are discarded.

Optional Feature:
CMD_TIMEOUT_EN:
- Defined:
  - A counter clears on entry to WAIT_ENG and increments each WAIT_ENG cycle.
  - When it reaches TIMEOUT_CYCLES without eng_done: eng_abort=1 for one cycle, error=1, go to RESPOND.
  - eng_done in the expiry cycle has priority, and its eng_err is used.
- Undefined: no counter; eng_abort is tied 0; WAIT_ENG waits indefinitely.

Decomposition:
- Package hps_cmd_pkg:
  - opcode constants OP_NOP=3'b000, OP_READ_NEXT=3'b111
  - status bit indices ST_DONE=0, ST_BUSY=1, ST_ERR=2
  - state enum {IDLE, EXEC, WAIT_ENG, RESPOND}
  - command field widths
- Sub-module rsp_byte_fifo:
  - Parameterised by RES_DEPTH.
  - Ports: push, pop, flush, din, dout, empty, full.

Test Plan:
1. NOP: cmd_word=18'h00000, raise cmd_valid → rsp_status=3'b001 two edges later, rsp_data unchanged; drop cmd_valid → rsp_status=3'b000.
2. Opcode 3'b010, operand 15'h1234 →
   - eng_start high exactly 1 cycle, eng_operand=15'h1234, busy=1.
   - Engine pushes 8'hA5, 8'h5A, then eng_done → status 3'b001.
   - Two READ_NEXT → rsp_data A5 then 5A.
   - Third READ_NEXT → status 3'b101.
3. Overflow: engine pushes 5 bytes with RES_DEPTH=4, then eng_done → status 3'b101; four READ_NEXT return bytes 1–4, fifth READ_NEXT flags error.
4. Same-cycle completion: res_valid=1 with res_data=8'h3C in the same cycle as eng_done → byte stored; READ_NEXT returns 8'h3C.
5. Reset asserted in WAIT_ENG with cmd_valid held high →
   - All outputs 0.
   - No accept after reset release until cmd_valid goes 0 then 1.
6. CMD_TIMEOUT_EN, TIMEOUT_CYCLES=16, no eng_done → eng_abort pulses once after 16 WAIT_ENG cycles; status 3'b101.
